reg_wb_commit: RTL and testbench

- Write end of the register-forwarding interface.
- Registers the access-stage (as) GPR/CSR write requests into the write-back (wb) stage and publishes them as wb_reg_wr_* / wb_csr_wr_* for the forwarding unit.
- Commits the wb-stage writes into the 32x32 GPR array and the machine CSR bank.
- Serves the combinational reg1/reg2/csr read ports used by decode.

---
 rtl/reg_wb_commit.sv | 182 ++++++++++++++++++
 tb/tb_reg_wb_commit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_commit.sv
// reg_wb_commit
//   Write end of the register-forwarding interface. This block registers the
//   access-stage GPR/CSR write requests into the write-back stage and publishes
//   them on wb_* for the forwarding unit. It commits those wb writes into the
//   GPR array and the machine CSR bank, and serves the combinational decode
//   read ports.
//
//   Ports:
//     clk, rst                 core clock, synchronous active-high reset
//     as_reg_wr_*              access-stage GPR write request
//     as_csr_wr_*              access-stage CSR write request
//     hold_i / flush_i         stall (freezes wb) / kill of the as->wb transfer
//     wb_reg_wr_* / wb_csr_wr_*  registered wb-stage write requests
//     reg1/reg2/csr_rd_*       combinational read ports
//
//   Optional build macro: WB_READ_BYPASS_EN. When it is defined, a read of the
//   address being committed this cycle returns the wb write data. When it is
//   not defined, reads return the pre-write state.
module reg_wb_commit #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      as_reg_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] as_reg_wr_adder_i,
  input  logic [CPU_WIDTH-1:0]      as_reg_wr_data_i,
  input  logic                      as_csr_wr_en_i,
  input  logic [CSR_ADDR_WIDTH-1:0] as_csr_wr_adder_i,
  input  logic [CPU_WIDTH-1:0]      as_csr_wr_data_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic                      wb_reg_wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      wb_reg_wr_data_o,
  output logic                      wb_csr_wr_en_o,
  output logic [CSR_ADDR_WIDTH-1:0] wb_csr_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      wb_csr_wr_data_o,
  input  logic [REG_ADDR_WIDTH-1:0] reg1_rd_adder_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg2_rd_adder_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_rd_adder_i,
  output logic [CPU_WIDTH-1:0]      reg1_rd_data_o,
  output logic [CPU_WIDTH-1:0]      reg2_rd_data_o,
  output logic [CPU_WIDTH-1:0]      csr_rd_data_o
);

  localparam int NUM_GPR = 1 << REG_ADDR_WIDTH;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS  = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIE      = CSR_ADDR_WIDTH'(12'h304);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC    = CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSCRATCH = CSR_ADDR_WIDTH'(12'h340);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC     = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE   = CSR_ADDR_WIDTH'(12'h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLE   = CSR_ADDR_WIDTH'(12'hB00);
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLEH  = CSR_ADDR_WIDTH'(12'hB80);

  // Reset value of mstatus: MPP = machine mode.
  localparam logic [CPU_WIDTH-1:0] MSTATUS_RST = CPU_WIDTH'(32'h0000_1800);

  logic [CPU_WIDTH-1:0]   gpr [NUM_GPR];
  logic [CPU_WIDTH-1:0]   mstatus, mie, mtvec, mscratch, mepc, mcause;
  logic [2*CPU_WIDTH-1:0] mcycle;

  logic                 reg_commit;
  logic                 csr_commit;
  logic [CPU_WIDTH-1:0] csr_wr_val;

  // A held wb write stays in place and retires on the edge where hold drops,
  // so hold must gate the commit. Writes to x0 are discarded here.
  assign reg_commit = wb_reg_wr_en_o && !hold_i && (wb_reg_wr_adder_o != '0);
  assign csr_commit = wb_csr_wr_en_o && !hold_i;
  assign csr_wr_val = (wb_csr_wr_adder_o == CSR_MEPC) ?
                      {wb_csr_wr_data_o[CPU_WIDTH-1:2], 2'b00} : wb_csr_wr_data_o;

  // as -> wb pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_wr_en_o    <= 1'b0;
      wb_reg_wr_adder_o <= '0;
      wb_reg_wr_data_o  <= '0;
      wb_csr_wr_en_o    <= 1'b0;
      wb_csr_wr_adder_o <= '0;
      wb_csr_wr_data_o  <= '0;
    end else if (flush_i) begin
      wb_reg_wr_en_o <= 1'b0;
      wb_csr_wr_en_o <= 1'b0;
    end else if (!hold_i) begin
      wb_reg_wr_en_o    <= as_reg_wr_en_i;
      wb_reg_wr_adder_o <= as_reg_wr_adder_i;
      wb_reg_wr_data_o  <= as_reg_wr_data_i;
      wb_csr_wr_en_o    <= as_csr_wr_en_i;
      wb_csr_wr_adder_o <= as_csr_wr_adder_i;
      wb_csr_wr_data_o  <= as_csr_wr_data_i;
    end
  end

  // GPR array commit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else if (reg_commit) begin
      gpr[wb_reg_wr_adder_o] <= wb_reg_wr_data_o;
    end
  end

  // CSR bank commit. mcycle counts every non-reset cycle. A committed write
  // to either half replaces that half and suppresses the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= MSTATUS_RST;
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
    end else begin
      if (csr_commit) begin
        case (wb_csr_wr_adder_o)
          CSR_MSTATUS:  mstatus  <= csr_wr_val;
          CSR_MIE:      mie      <= csr_wr_val;
          CSR_MTVEC:    mtvec    <= csr_wr_val;
          CSR_MSCRATCH: mscratch <= csr_wr_val;
          CSR_MEPC:     mepc     <= csr_wr_val;
          CSR_MCAUSE:   mcause   <= csr_wr_val;
          default: ;
        endcase
      end
      if (csr_commit && wb_csr_wr_adder_o == CSR_MCYCLE)
        mcycle[CPU_WIDTH-1:0] <= csr_wr_val;
      else if (csr_commit && wb_csr_wr_adder_o == CSR_MCYCLEH)
        mcycle[2*CPU_WIDTH-1:CPU_WIDTH] <= csr_wr_val;
      else
        mcycle <= mcycle + (2*CPU_WIDTH)'(1);
    end
  end

`ifdef WB_READ_BYPASS_EN
  logic wb_csr_impl;
  always_comb begin
    wb_csr_impl = 1'b0;
    case (wb_csr_wr_adder_o)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH: wb_csr_impl = 1'b1;
      default: wb_csr_impl = 1'b0;
    endcase
  end
`endif

  always_comb begin
    reg1_rd_data_o = (reg1_rd_adder_i == '0) ? '0 : gpr[reg1_rd_adder_i];
    reg2_rd_data_o = (reg2_rd_adder_i == '0) ? '0 : gpr[reg2_rd_adder_i];
`ifdef WB_READ_BYPASS_EN
    if (reg_commit && !rst && reg1_rd_adder_i == wb_reg_wr_adder_o)
      reg1_rd_data_o = wb_reg_wr_data_o;
    if (reg_commit && !rst && reg2_rd_adder_i == wb_reg_wr_adder_o)
      reg2_rd_data_o = wb_reg_wr_data_o;
`endif
  end

  always_comb begin
    csr_rd_data_o = '0;
    case (csr_rd_adder_i)
      CSR_MSTATUS:  csr_rd_data_o = mstatus;
      CSR_MIE:      csr_rd_data_o = mie;
      CSR_MTVEC:    csr_rd_data_o = mtvec;
      CSR_MSCRATCH: csr_rd_data_o = mscratch;
      CSR_MEPC:     csr_rd_data_o = mepc;
      CSR_MCAUSE:   csr_rd_data_o = mcause;
      CSR_MCYCLE:   csr_rd_data_o = mcycle[CPU_WIDTH-1:0];
      CSR_MCYCLEH:  csr_rd_data_o = mcycle[2*CPU_WIDTH-1:CPU_WIDTH];
      default:      csr_rd_data_o = '0;
    endcase
`ifdef WB_READ_BYPASS_EN
    if (csr_commit && !rst && wb_csr_impl && csr_rd_adder_i == wb_csr_wr_adder_o)
      csr_rd_data_o = csr_wr_val;
`endif
  end

endmodule

// File: tb/tb_reg_wb_commit.sv
// tb_reg_wb_commit
//   Directed scenarios followed by randomized traffic. The reference model
//   below tracks the register file and CSR bank as plain arrays.
module tb_reg_wb_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_reg_wr_en_i;
  logic [4:0]  as_reg_wr_adder_i;
  logic [31:0] as_reg_wr_data_i;
  logic        as_csr_wr_en_i;
  logic [11:0] as_csr_wr_adder_i;
  logic [31:0] as_csr_wr_data_i;
  logic        hold_i;
  logic        flush_i;
  logic        wb_reg_wr_en_o;
  logic [4:0]  wb_reg_wr_adder_o;
  logic [31:0] wb_reg_wr_data_o;
  logic        wb_csr_wr_en_o;
  logic [11:0] wb_csr_wr_adder_o;
  logic [31:0] wb_csr_wr_data_o;
  logic [4:0]  reg1_rd_adder_i;
  logic [4:0]  reg2_rd_adder_i;
  logic [11:0] csr_rd_adder_i;
  logic [31:0] reg1_rd_data_o;
  logic [31:0] reg2_rd_data_o;
  logic [31:0] csr_rd_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_wb_commit dut (
    .clk               (clk),
    .rst               (rst),
    .as_reg_wr_en_i    (as_reg_wr_en_i),
    .as_reg_wr_adder_i (as_reg_wr_adder_i),
    .as_reg_wr_data_i  (as_reg_wr_data_i),
    .as_csr_wr_en_i    (as_csr_wr_en_i),
    .as_csr_wr_adder_i (as_csr_wr_adder_i),
    .as_csr_wr_data_i  (as_csr_wr_data_i),
    .hold_i            (hold_i),
    .flush_i           (flush_i),
    .wb_reg_wr_en_o    (wb_reg_wr_en_o),
    .wb_reg_wr_adder_o (wb_reg_wr_adder_o),
    .wb_reg_wr_data_o  (wb_reg_wr_data_o),
    .wb_csr_wr_en_o    (wb_csr_wr_en_o),
    .wb_csr_wr_adder_o (wb_csr_wr_adder_o),
    .wb_csr_wr_data_o  (wb_csr_wr_data_o),
    .reg1_rd_adder_i   (reg1_rd_adder_i),
    .reg2_rd_adder_i   (reg2_rd_adder_i),
    .csr_rd_adder_i    (csr_rd_adder_i),
    .reg1_rd_data_o    (reg1_rd_data_o),
    .reg2_rd_data_o    (reg2_rd_data_o),
    .csr_rd_data_o     (csr_rd_data_o)
  );

  // reference model state
  logic        m_wb_reg_en;
  logic [4:0]  m_wb_reg_addr;
  logic [31:0] m_wb_reg_data;
  logic        m_wb_csr_en;
  logic [11:0] m_wb_csr_addr;
  logic [31:0] m_wb_csr_data;
  logic [31:0] m_gpr [32];
  logic [31:0] m_csr [4096];
  logic [63:0] m_mcycle;

  logic [11:0] csr_pool [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'hB00, 12'hB80, 12'h7C0, 12'h000};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80};
  endfunction

  function automatic logic [31:0] exp_gpr(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_gpr[a];
`ifdef WB_READ_BYPASS_EN
    if (!rst && !hold_i && m_wb_reg_en && a != 5'd0 && a == m_wb_reg_addr) v = m_wb_reg_data;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_csr(input logic [11:0] a);
    logic [31:0] v;
    if (a == 12'hB00)      v = m_mcycle[31:0];
    else if (a == 12'hB80) v = m_mcycle[63:32];
    else if (is_impl(a))   v = m_csr[a];
    else                   v = 32'd0;
`ifdef WB_READ_BYPASS_EN
    if (!rst && !hold_i && m_wb_csr_en && is_impl(a) && a == m_wb_csr_addr)
      v = (a == 12'h341) ? (m_wb_csr_data & ~32'h3) : m_wb_csr_data;
`endif
    return v;
  endfunction

  // One clock edge of the reference model, using the inputs as they stand.
  task automatic model_step();
    bit commit_reg, commit_csr, cyc_written;
    commit_reg = m_wb_reg_en && !hold_i && m_wb_reg_addr != 5'd0;
    commit_csr = m_wb_csr_en && !hold_i;
    if (rst) begin
      foreach (m_gpr[i]) m_gpr[i] = 32'd0;
      foreach (m_csr[i]) m_csr[i] = 32'd0;
      m_csr[12'h300] = 32'h0000_1800;
      m_mcycle = 64'd0;
      m_wb_reg_en = 1'b0; m_wb_reg_addr = '0; m_wb_reg_data = '0;
      m_wb_csr_en = 1'b0; m_wb_csr_addr = '0; m_wb_csr_data = '0;
    end else begin
      if (commit_reg) m_gpr[m_wb_reg_addr] = m_wb_reg_data;
      cyc_written = 1'b0;
      if (commit_csr) begin
        if (m_wb_csr_addr == 12'hB00) begin
          m_mcycle[31:0] = m_wb_csr_data; cyc_written = 1'b1;
        end else if (m_wb_csr_addr == 12'hB80) begin
          m_mcycle[63:32] = m_wb_csr_data; cyc_written = 1'b1;
        end else if (m_wb_csr_addr == 12'h341) begin
          m_csr[12'h341] = m_wb_csr_data & ~32'h3;
        end else if (is_impl(m_wb_csr_addr)) begin
          m_csr[m_wb_csr_addr] = m_wb_csr_data;
        end
      end
      if (!cyc_written) m_mcycle = m_mcycle + 64'd1;
      if (flush_i) begin
        m_wb_reg_en = 1'b0;
        m_wb_csr_en = 1'b0;
      end else if (!hold_i) begin
        m_wb_reg_en = as_reg_wr_en_i; m_wb_reg_addr = as_reg_wr_adder_i; m_wb_reg_data = as_reg_wr_data_i;
        m_wb_csr_en = as_csr_wr_en_i; m_wb_csr_addr = as_csr_wr_adder_i; m_wb_csr_data = as_csr_wr_data_i;
      end
    end
  endtask

  task automatic check_all();
    check_eq("wb_reg_en", wb_reg_wr_en_o, m_wb_reg_en);
    if (m_wb_reg_en) begin
      check_eq("wb_reg_addr", wb_reg_wr_adder_o, m_wb_reg_addr);
      check_eq("wb_reg_data", wb_reg_wr_data_o, m_wb_reg_data);
    end
    check_eq("wb_csr_en", wb_csr_wr_en_o, m_wb_csr_en);
    if (m_wb_csr_en) begin
      check_eq("wb_csr_addr", wb_csr_wr_adder_o, m_wb_csr_addr);
      check_eq("wb_csr_data", wb_csr_wr_data_o, m_wb_csr_data);
    end
    check_eq("reg1_rd", reg1_rd_data_o, exp_gpr(reg1_rd_adder_i));
    check_eq("reg2_rd", reg2_rd_data_o, exp_gpr(reg2_rd_adder_i));
    check_eq("csr_rd", csr_rd_data_o, exp_csr(csr_rd_adder_i));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    as_reg_wr_en_i = 1'b0; as_reg_wr_adder_i = '0; as_reg_wr_data_i = '0;
    as_csr_wr_en_i = 1'b0; as_csr_wr_adder_i = '0; as_csr_wr_data_i = '0;
    reg1_rd_adder_i = 5'd5; reg2_rd_adder_i = '0; csr_rd_adder_i = 12'h300;
    step();
    step();
    check_eq("rst_wb_reg_en", wb_reg_wr_en_o, 1'b0);
    check_eq("rst_rd_x5", reg1_rd_data_o, 32'd0);
    check_eq("rst_mstatus", csr_rd_data_o, 32'h0000_1800);

    rst = 1'b0; csr_rd_adder_i = 12'hB00;
    step();
    check_eq("mcycle_first", csr_rd_data_o, 32'd1);

    // x5 write, then read back
    as_reg_wr_en_i = 1'b1; as_reg_wr_adder_i = 5'd5; as_reg_wr_data_i = 32'hDEAD_BEEF;
    step();
    check_eq("wb_x5_addr", wb_reg_wr_adder_o, 5'd5);
    check_eq("wb_x5_data", wb_reg_wr_data_o, 32'hDEAD_BEEF);
    as_reg_wr_en_i = 1'b0;
    step();
    check_eq("rd_x5", reg1_rd_data_o, 32'hDEAD_BEEF);

    // x0 write is discarded
    as_reg_wr_en_i = 1'b1; as_reg_wr_adder_i = 5'd0; as_reg_wr_data_i = 32'hCAFE_0000;
    step();
    as_reg_wr_en_i = 1'b0; reg1_rd_adder_i = 5'd0;
    step();
    check_eq("rd_x0", reg1_rd_data_o, 32'd0);

    // held wb write retires once, after hold drops
    as_reg_wr_en_i = 1'b1; as_reg_wr_adder_i = 5'd7; as_reg_wr_data_i = 32'h11;
    step();
    as_reg_wr_en_i = 1'b0; hold_i = 1'b1; reg1_rd_adder_i = 5'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("hold_wb_addr", wb_reg_wr_adder_o, 5'd7);
      check_eq("hold_wb_data", wb_reg_wr_data_o, 32'h11);
      check_eq("hold_rd_x7", reg1_rd_data_o, 32'd0);
    end
    hold_i = 1'b0;
    step();
    check_eq("rd_x7", reg1_rd_data_o, 32'h11);

    // flush overrides hold
    as_reg_wr_en_i = 1'b1; as_reg_wr_adder_i = 5'd8; as_reg_wr_data_i = 32'h88;
    step();
    flush_i = 1'b1; hold_i = 1'b1;
    step();
    check_eq("flush_hold_en", wb_reg_wr_en_o, 1'b0);
    flush_i = 1'b0; hold_i = 1'b0; as_reg_wr_en_i = 1'b0;

    // mepc masking and unimplemented CSR
    as_csr_wr_en_i = 1'b1; as_csr_wr_adder_i = 12'h341; as_csr_wr_data_i = 32'h8000_0003;
    step();
    as_csr_wr_en_i = 1'b0; csr_rd_adder_i = 12'h341;
    step();
    check_eq("rd_mepc", csr_rd_data_o, 32'h8000_0000);
    as_csr_wr_en_i = 1'b1; as_csr_wr_adder_i = 12'h7C0; as_csr_wr_data_i = 32'h1234_5678;
    step();
    as_csr_wr_en_i = 1'b0; csr_rd_adder_i = 12'h7C0;
    step();
    check_eq("rd_unimpl", csr_rd_data_o, 32'd0);

    // mcycle preset to all ones, then wrap
    as_csr_wr_en_i = 1'b1; as_csr_wr_adder_i = 12'hB00; as_csr_wr_data_i = 32'hFFFF_FFFF;
    step();
    as_csr_wr_adder_i = 12'hB80;
    step();
    as_csr_wr_en_i = 1'b0; csr_rd_adder_i = 12'hB00;
    step();
    check_eq("mcycle_lo_ones", csr_rd_data_o, 32'hFFFF_FFFF);
    csr_rd_adder_i = 12'hB80; #1;
    check_eq("mcycle_hi_ones", csr_rd_data_o, 32'hFFFF_FFFF);
    csr_rd_adder_i = 12'hB00;
    step();
    check_eq("mcycle_lo_wrap", csr_rd_data_o, 32'd0);
    csr_rd_adder_i = 12'hB80; #1;
    check_eq("mcycle_hi_wrap", csr_rd_data_o, 32'd0);

    // same-cycle commit and read of x9
    as_reg_wr_en_i = 1'b1; as_reg_wr_adder_i = 5'd9; as_reg_wr_data_i = 32'h1234;
    step();
    as_reg_wr_en_i = 1'b0; reg1_rd_adder_i = 5'd9; #1;
`ifdef WB_READ_BYPASS_EN
    check_eq("bypass_x9", reg1_rd_data_o, 32'h1234);
`else
    check_eq("bypass_x9", reg1_rd_data_o, 32'd0);
`endif
    step();
    check_eq("rd_x9", reg1_rd_data_o, 32'h1234);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      flush_i = ($urandom_range(0, 99) < 8);
      hold_i  = ($urandom_range(0, 99) < 20);
      as_reg_wr_en_i    = $urandom_range(0, 1) == 1;
      as_reg_wr_adder_i = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      as_reg_wr_data_i  = $urandom;
      as_csr_wr_en_i    = ($urandom_range(0, 3) == 0);
      as_csr_wr_adder_i = csr_pool[$urandom_range(0, 9)];
      as_csr_wr_data_i  = $urandom;
      reg1_rd_adder_i   = 5'($urandom_range(0, 7));
      reg2_rd_adder_i   = 5'($urandom_range(0, 31));
      csr_rd_adder_i    = csr_pool[$urandom_range(0, 9)];
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
